// File: rtl/mul8_sequencer.sv
// mul8_sequencer: 8x8 multiplier time-sharing one 4x4 product unit over four steps; MUL8_SIGNED_EN adds signed_op.
module mul8_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
`ifdef MUL8_SIGNED_EN
  input  logic        signed_op,
`endif
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        busy,
  output logic        done,
  output logic [15:0] P
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t      r_state;
  logic [1:0]  r_step;
  logic [7:0]  r_a, r_b;
  logic [15:0] r_acc, r_p;
  logic        r_neg, r_busy, r_done;
  logic [7:0]  w_a, w_b, w_pp;
  logic        w_neg;
  logic [3:0]  w_an, w_bn, w_shamt;
  logic [15:0] w_sum, w_fin;
`ifdef MUL8_SIGNED_EN
  // Magnitudes of 8'h80 fit unsigned in 8 bits, so the sequence stays unsigned.
  assign w_neg = signed_op & (A[7] ^ B[7]);
  assign w_a   = (signed_op & A[7]) ? -A : A;
  assign w_b   = (signed_op & B[7]) ? -B : B;
`else
  assign w_neg = 1'b0;
  assign w_a   = A;
  assign w_b   = B;
`endif
  assign w_an    = r_step[1] ? r_a[7:4] : r_a[3:0];
  assign w_bn    = r_step[0] ? r_b[7:4] : r_b[3:0];
  assign w_pp    = {4'd0, w_an} * {4'd0, w_bn};
  assign w_shamt = {r_step[1] & r_step[0], r_step[1] ^ r_step[0], 2'b00};
  assign w_sum   = r_acc + ({8'd0, w_pp} << w_shamt);
  assign w_fin   = r_neg ? -w_sum : w_sum;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_step  <= 2'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_neg   <= 1'b0;
      r_acc   <= 16'd0;
      r_p     <= 16'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (start && r_state != S_MUL) begin
        r_a     <= w_a;
        r_b     <= w_b;
        r_neg   <= w_neg;
        r_acc   <= 16'd0;
        r_step  <= 2'd0;
        r_state <= S_MUL;
        r_busy  <= 1'b1;
      end else if (r_state == S_MUL) begin
        r_acc  <= w_sum;
        r_step <= r_step + 2'd1;
        if (r_step == 2'd3) begin
          r_state <= S_DONE;
          r_p     <= w_fin;
          r_done  <= 1'b1;
        end
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;
endmodule

// File: tb/tb_mul8_sequencer.sv
// tb_mul8_sequencer: directed self-checking bench for mul8_sequencer; signed cases built with MUL8_SIGNED_EN.
module tb_mul8_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0]  A = 8'd0, B = 8'd0;
  logic        busy, done;
  logic [15:0] P;
  int          n_chk = 0, n_fail = 0;
`ifdef MUL8_SIGNED_EN
  logic signed_op = 1'b0;
`endif
  mul8_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef MUL8_SIGNED_EN
    .signed_op(signed_op),
`endif
    .A(A), .B(B), .busy(busy), .done(done), .P(P)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    A = a;
    B = b;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
    repeat (3) begin
      cyc();
      chk({tag, "_nodone"}, {15'd0, done}, 16'd0);
    end
    cyc();
    chk({tag, "_done"}, {15'd0, done}, 16'd1);
    chk({tag, "_P"}, P, exp);
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_P", P, 16'h0000);
    reset = 1'b0;
    cyc();
    op("t1", 8'h12, 8'h34, 16'h03A8);
    cyc();
    chk("t1_pulse", {15'd0, done}, 16'd0);
    chk("t1_idle", {15'd0, busy}, 16'd0);
    chk("t1_hold", P, 16'h03A8);
    op("t2a", 8'hFF, 8'hFF, 16'hFE01);
    A = 8'h00;
    B = 8'h5A;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_b2b_busy", {15'd0, busy}, 16'd1);
    chk("t2_b2b_done", {15'd0, done}, 16'd0);
    chk("t2_b2b_Phold", P, 16'hFE01);
    repeat (3) begin
      cyc();
      chk("t2b_nodone", {15'd0, done}, 16'd0);
    end
    cyc();
    chk("t2b_done", {15'd0, done}, 16'd1);
    chk("t2b_P", P, 16'h0000);
    cyc();
    A = 8'h12;
    B = 8'h34;
    start = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      A = i[0] ? 8'hFF : 8'h00;
      B = i[0] ? 8'h00 : 8'hFF;
      cyc();
      chk("t3_nodone", {15'd0, done}, 16'd0);
    end
    start = 1'b0;
    cyc();
    chk("t3_done", {15'd0, done}, 16'd1);
    chk("t3_P", P, 16'h03A8);
    cyc();
    chk("t3_single", {15'd0, done}, 16'd0);
    chk("t3_idle", {15'd0, busy}, 16'd0);
    A = 8'hFF;
    B = 8'hFF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t4_abort_busy", {15'd0, busy}, 16'd0);
    chk("t4_abort_done", {15'd0, done}, 16'd0);
    chk("t4_abort_P", P, 16'h03A8);
    repeat (4) begin
      cyc();
      chk("t4_abort_nodone", {15'd0, done}, 16'd0);
    end
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("t4_abort_wins", {15'd0, busy}, 16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_rst_P", P, 16'h0000);
    chk("t5_rst_busy", {15'd0, busy}, 16'd0);
    chk("t5_rst_done", {15'd0, done}, 16'd0);
    repeat (4) begin
      cyc();
      chk("t5_rst_nodone", {15'd0, done}, 16'd0);
    end
    op("t6", 8'h0F, 8'hF0, 16'h0E10);
    cyc();
`ifdef MUL8_SIGNED_EN
    signed_op = 1'b1;
    op("s1", 8'h80, 8'h80, 16'h4000);
    cyc();
    op("s2", 8'h80, 8'h7F, 16'hC080);
    cyc();
    op("s3", 8'hFF, 8'hFF, 16'h0001);
    cyc();
    op("s4", 8'hFE, 8'h03, 16'hFFFA);
    cyc();
    signed_op = 1'b0;
    op("s5", 8'hFF, 8'hFF, 16'hFE01);
    cyc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul8_sequencer.md
MUL8_SEQUENCER -- requirements
Module: mul8_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled on the rising edge of clk.
REQ-005 abort  input  1  cancel the operation in flight; returns the block to IDLE.
REQ-006 A  input  8  multiplicand; captured only when start is accepted.
REQ-007 B  input  8  multiplier; captured only when start is accepted.
REQ-008 busy  output  1  an operation is in progress (states MUL and DONE).
REQ-009 done  output  1  one-cycle pulse; P is valid in that cycle.
REQ-010 P  output  16  registered product; holds its value until the next accepted start.

Function
REQ-011 Datapath: exactly one 4x4 unsigned combinational product unit (8-bit exact result), time-shared over four steps.
REQ-012 States: IDLE, MUL (step counter 0..3), DONE; encoding is free.
REQ-013 IDLE + start=1 -> capture A, B; clear the accumulator; go to MUL with step=0.
REQ-014 Each MUL step adds one partial product to the 16-bit accumulator:
- step 0: a_lo*b_lo, shift 0
- step 1: a_lo*b_hi, shift 4
- step 2: a_hi*b_lo, shift 4
- step 3: a_hi*b_hi, shift 8
REQ-015 Accumulation is modulo 2^16; the exact unsigned result never overflows.
REQ-016 MUL with step=3 -> DONE; P is loaded from the final accumulator sum.
REQ-017 Latency: start accepted at edge n -> done=1 and P valid in the cycle following edge n+4 (4 MUL cycles, then DONE).
REQ-018 done is high only in DONE and for exactly one cycle; busy is high in MUL and DONE.
REQ-019 DONE + start=0 -> IDLE.
REQ-020 DONE + start=1 -> new operation accepted (back-to-back, no idle gap); done stays 1 for that cycle.
REQ-021 start in MUL is ignored; captured operands are not disturbed.
REQ-022 Changes to A or B after capture have no effect on the result.
REQ-023 abort=1 in MUL or DONE -> IDLE at the next edge; P is not updated; done is not pulsed.
REQ-024 abort=1 and start=1 in the same cycle -> abort wins; no capture.
REQ-025 abort in IDLE has no effect.

Reset
REQ-026 reset=1 at a rising edge -> state IDLE, step=0, accumulator=0, P=16'h0000, busy=0, done=0.
REQ-027 Reset has priority over start and abort and is effective mid-operation; no done pulse follows a reset.

Configuration
REQ-028 Macro MUL8_SIGNED_EN defined -> add input port signed_op (1 bit), captured with A and B on start.
- signed_op=1: A and B are two's complement; magnitudes feed the 4-step sequence; P is the negated result when operand signs differ.
- The sign correction is applied at the MUL->DONE transition, so latency is unchanged.
REQ-029 Macro MUL8_SIGNED_EN not defined -> no signed_op port; unsigned operation only; behaviour as in REQ-011..REQ-025.

Verification
REQ-030 The bench SHALL cover at least the following directed scenarios:
- A=8'h12, B=8'h34, start pulse -> done exactly 5 cycles after start, P=16'h03A8.
- A=8'hFF, B=8'hFF -> P=16'hFE01; immediately after, start in the DONE cycle with A=8'h00, B=8'h5A -> second done 5 cycles later, P=16'h0000.
- start re-asserted and A/B toggled during MUL -> result unchanged, only one done pulse.
- abort in MUL step 2 -> busy=0 next cycle, no done, P retains its previous value; reset mid-MUL -> P=16'h0000, busy=0, done=0.
- MUL8_SIGNED_EN, signed_op=1:
  - A=8'h80, B=8'h80 -> P=16'h4000
  - A=8'h80, B=8'h7F -> P=16'hC080
  - A=8'hFF, B=8'hFF -> P=16'h0001
- MUL8_SIGNED_EN, signed_op=0: A=8'hFF, B=8'hFF -> P=16'hFE01.
